// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory between an instruction-fetch requester and a
//   data (load/store) requester. Data accesses normally win arbitration, but a
//   waiting fetch is guaranteed service after MAX_DM_STREAK consecutive data
//   grants. Each access costs one IDLE decision cycle plus one or more GRANT
//   cycles, ending on the cycle mem_ready is seen.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_ack) and word address
//   if_ack/if_rdata          fetch completion pulse and read data
//   dm_req/dm_we/dm_byte     data request, store flag, byte-wide flag
//   dm_addr/dm_wdata         data address and store data
//   dm_ack/dm_rdata          data completion pulse and load data
//   mem_req/mem_we/mem_byte  memory command (driven from captured registers)
//   mem_addr/mem_wdata       memory address and write data
//   mem_rdata/mem_ready      memory response; mem_ready ends the access
//   stall                    pipeline freeze while any request is outstanding
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MAX_DM_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_byte,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall
);

    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_DM = 2'd2
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_streak;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_we;
    logic          r_byte;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_dm_rdata;

    logic w_fetch_wins;
    logic w_granted;
    logic w_if_ack;
    logic w_dm_ack;

    // Fetch wins only when it is alone, or when data has already had its
    // allotted run of grants while the fetch was waiting.
    assign w_fetch_wins = if_req & (~dm_req | (r_streak == STREAK_MAX));

    // Outputs are qualified with rst so an access in flight is dropped on the
    // very cycle reset is raised, not one edge later.
    assign w_granted = ~rst & (r_state != IDLE);
    assign w_if_ack  = ~rst & (r_state == GRANT_IF) & mem_ready;
    assign w_dm_ack  = ~rst & (r_state == GRANT_DM) & mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_streak   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_byte     <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fetch_wins) begin
                        r_state  <= GRANT_IF;
                        r_addr   <= if_addr;
                        r_we     <= 1'b0;
                        r_byte   <= 1'b0;
                        r_wdata  <= '0;
                        r_streak <= '0;
                    end else if (dm_req) begin
                        r_state <= GRANT_DM;
                        r_addr  <= dm_addr;
                        r_we    <= dm_we;
                        r_byte  <= dm_byte;
                        r_wdata <= dm_wdata;
                        // Streak only counts grants that made a fetch wait.
                        if (if_req) begin
                            if (r_streak != STREAK_MAX) begin
                                r_streak <= r_streak + SW'(1);
                            end
                        end else begin
                            r_streak <= '0;
                        end
                    end
                end
                GRANT_IF: begin
                    if (mem_ready) begin
                        r_if_rdata <= mem_rdata;
                        r_state    <= IDLE;
                    end
                end
                GRANT_DM: begin
                    if (mem_ready) begin
                        // Stores leave the last load result intact.
                        if (!r_we) begin
                            r_dm_rdata <= mem_rdata;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req   = w_granted;
    assign mem_we    = w_granted & r_we;
    assign mem_byte  = r_byte;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_ack = w_if_ack;
    assign dm_ack = w_dm_ack;

    // Read data is forwarded straight from memory in the ack cycle, then held.
    assign if_rdata = rst ? 32'd0 : (w_if_ack ? mem_rdata : r_if_rdata);
    assign dm_rdata = rst ? 32'd0 : ((w_dm_ack & ~r_we) ? mem_rdata : r_dm_rdata);

    assign stall = (if_req & ~w_if_ack) | (dm_req & ~w_dm_ack);

endmodule
